// File: rtl/dmux_stream_router_1by2.sv
// Handshaked 1:2 stream demultiplexer with a one-word output register per channel,
// an optional strict round-robin target, and per-channel accepted-word counters.
module dmux_stream_router_1by2 #(
  parameter int DATA_W      = 8,
  parameter int ROUND_ROBIN = 0,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sel,
  output logic              in_ready,
  output logic [DATA_W-1:0] y0_data,
  output logic              y0_valid,
  input  logic              y0_ready,
  output logic [DATA_W-1:0] y1_data,
  output logic              y1_valid,
  input  logic              y1_ready,
  output logic              rr_ptr,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  localparam bit RR_EN = (ROUND_ROBIN != 0);

  logic                   rr_q, rr_d;
  logic                   tgt;
  logic                   acc;
  logic [1:0]             valid_all;
  logic [1:0]             ready_all;
  logic [1:0][DATA_W-1:0] data_all;
  logic [1:0][CNT_W-1:0]  cnt_all;

  assign ready_all = {y1_ready, y0_ready};
  assign tgt       = RR_EN ? rr_q : in_sel;

  // Only the target channel gates acceptance; in round-robin mode a stalled
  // target blocks the input rather than letting the pointer skip ahead.
  assign in_ready = rst_n & (~valid_all[tgt] | ready_all[tgt]);
  assign acc      = in_valid & in_ready;

  always_comb begin
    rr_d = rr_q;
    if (RR_EN && acc) begin
      rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [DATA_W-1:0] data_q, data_d;
      logic              valid_q, valid_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic              acc_ch;

      assign acc_ch = acc & (tgt == 1'(gi));

      // A same-cycle drain and accept overwrites the slot, keeping valid high.
      always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (acc_ch) begin
          data_d  = in_data;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (valid_q && ready_all[gi]) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
          cnt_q   <= cnt_d;
        end
      end

      assign valid_all[gi] = valid_q;
      assign data_all[gi]  = data_q;
      assign cnt_all[gi]   = cnt_q;
    end
  endgenerate

  assign y0_data  = data_all[0];
  assign y0_valid = valid_all[0];
  assign y1_data  = data_all[1];
  assign y1_valid = valid_all[1];
  assign cnt0     = cnt_all[0];
  assign cnt1     = cnt_all[1];
  assign rr_ptr   = rr_q;

endmodule
